// File: rtl/bit_balance_tracker_pkg.sv
// Shared constants for the bit balance tracker: FSM state codes, defaults and
// widths of the summary-record fields.
package bit_balance_tracker_pkg;

  localparam int DEF_CNT_W  = 8;
  localparam int DEF_THRESH = 16;
  localparam int BYTE_W     = 8;
  localparam int POP_W      = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCUM  = 2'd1;
  localparam logic [1:0] ST_REPORT = 2'd2;

  // ones never exceeds 8*(2^cnt_w-1), so three extra bits suffice
  function automatic int ones_w(input int cnt_w);
    return cnt_w + 3;
  endfunction

  // one more bit than ones_w for the sign of the disparity
  function automatic int disp_w(input int cnt_w);
    return cnt_w + 4;
  endfunction

endpackage

// File: rtl/bit_balance_tracker_if.sv
// Byte-stream input and summary-record output of the bit balance tracker.
interface bit_balance_tracker_if
  import bit_balance_tracker_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);
  logic                  in_valid;
  logic                  in_ready;
  logic [BYTE_W-1:0]     in_data;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [CNT_W+2:0]      out_ones;
  logic [CNT_W-1:0]      out_bytes;
  logic [CNT_W+3:0]      out_disp;
  logic [CNT_W+3:0]      out_peak;
  logic                  out_balanced;
  logic                  out_alarm;
  logic                  out_len_err;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_ones, out_bytes, out_disp, out_peak,
           out_balanced, out_alarm, out_len_err
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_ones, out_bytes, out_disp, out_peak,
           out_balanced, out_alarm, out_len_err
  );
endinterface

// File: rtl/bit_balance_tracker_byte_popcount.sv
// Combinational set-bit counter for one byte (result 0..8).
module bit_balance_tracker_byte_popcount
  import bit_balance_tracker_pkg::*;
(
  input  logic [BYTE_W-1:0] data,
  output logic [POP_W-1:0]  count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < BYTE_W; i++) begin
      count = count + POP_W'(data[i]);
    end
  end

endmodule

// File: rtl/bit_balance_tracker.sv
// Per-frame bit balance monitor: accumulates ones, byte count, running
// disparity and peak |disparity|, then holds one summary record until taken.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for first byte; record fields hold last frame
// ST_ACCUM  | frame in progress, accumulating each accepted byte
// ST_REPORT | record valid, input stalled until out_ready
module bit_balance_tracker
  import bit_balance_tracker_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int THRESH = DEF_THRESH
) (
  input logic                  clk,
  input logic                  rst_n,
  bit_balance_tracker_if.slave bus
);

  localparam int                OW        = ones_w(CNT_W);
  localparam int                DW        = disp_w(CNT_W);
  localparam logic [CNT_W-1:0]  MAX_BYTES = '1;
  localparam logic [31:0]       THR       = THRESH;

  logic [1:0]           state, state_nx;
  logic [OW-1:0]        ones, ones_nx;
  logic [CNT_W-1:0]     nbytes, nbytes_nx;
  logic signed [DW-1:0] disp, disp_nx, d, disp_sum;
  logic [DW-1:0]        peak, peak_nx, disp_abs;
  logic                 len_err, len_err_nx;
  logic                 balanced, alarm;
  logic [POP_W-1:0]     pop;
  logic                 accept;

  bit_balance_tracker_byte_popcount u_popcount (
    .data  (bus.in_data),
    .count (pop)
  );

  assign accept   = bus.in_valid & bus.in_ready;
  // d = 2*pop - 8 in two's complement
  assign d        = DW'({pop, 1'b0}) - DW'(8);
  assign disp_sum = (state == ST_IDLE) ? d : disp + d;
  assign disp_abs = disp_sum[DW-1] ? -disp_sum : disp_sum;

  always_comb begin
    state_nx   = state;
    ones_nx    = ones;
    nbytes_nx  = nbytes;
    disp_nx    = disp;
    peak_nx    = peak;
    len_err_nx = len_err;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          ones_nx    = OW'(pop);
          nbytes_nx  = CNT_W'(1);
          disp_nx    = disp_sum;
          peak_nx    = disp_abs;
          len_err_nx = 1'b0;
          state_nx   = bus.in_last ? ST_REPORT : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (accept) begin
          // bytes past the length limit are swallowed, not accumulated
          if (nbytes == MAX_BYTES) begin
            len_err_nx = 1'b1;
          end else begin
            ones_nx   = ones + OW'(pop);
            nbytes_nx = nbytes + CNT_W'(1);
            disp_nx   = disp_sum;
            if (disp_abs > peak) peak_nx = disp_abs;
          end
          if (bus.in_last) state_nx = ST_REPORT;
        end
      end
      ST_REPORT: begin
        if (bus.out_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ones     <= '0;
      nbytes   <= '0;
      disp     <= '0;
      peak     <= '0;
      len_err  <= 1'b0;
      balanced <= 1'b0;
      alarm    <= 1'b0;
    end else begin
      state   <= state_nx;
      ones    <= ones_nx;
      nbytes  <= nbytes_nx;
      disp    <= disp_nx;
      peak    <= peak_nx;
      len_err <= len_err_nx;
      // flags only move with the data so the reset record stays all-zero
      if (accept) begin
        balanced <= (disp_nx == '0);
        alarm    <= (32'(peak_nx) > THR);
      end
    end
  end

  assign bus.in_ready     = (state != ST_REPORT);
  assign bus.out_valid    = (state == ST_REPORT);
  assign bus.out_ones     = ones;
  assign bus.out_bytes    = nbytes;
  assign bus.out_disp     = disp;
  assign bus.out_peak     = peak;
  assign bus.out_balanced = balanced;
  assign bus.out_alarm    = alarm;
  assign bus.out_len_err  = len_err;

endmodule
